// File: rtl/activation_unit.sv
// activation_unit: per-lane activation (ReLU, leaky ReLU, ReLU6, pass-through)
// over a LANES-wide, valid/ready streamed vector. It uses a two-stage pipeline
// with full-rate backpressure, vector framing from an internal beat counter,
// and reporting of length errors against the producer's in_last marker.
module activation_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LANES      = 4,
    parameter int VEC_LEN    = 128,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          out_last,
    output logic                          done,
    output logic                          busy,
    output logic                          len_err
);

    localparam int BEATS = VEC_LEN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_RELU6 = 2'b10;
    localparam logic [1:0] MODE_PASS  = 2'b11;

    // 6.0 in the chosen fixed-point format (16'h0600 for Q8.8)
    localparam logic signed [DATA_WIDTH-1:0] RELU6_MAX = DATA_WIDTH'(6 << FRAC_BITS);

    // Beat framing
    logic [CNT_W-1:0]             cnt;
    logic [1:0]                   mode_q;
    logic                         at_first;
    logic                         at_last;
    logic [1:0]                   beat_mode;
    logic                         beat_last;
    logic                         in_hs;

    // Pipeline stage 1: raw beat plus the mode it must be processed with
    logic                         s1_valid;
    logic [LANES*DATA_WIDTH-1:0]  s1_data;
    logic [1:0]                   s1_mode;
    logic                         s1_last;
    logic                         s1_adv;

    // Pipeline stage 2: activated beat, drives the output port directly
    logic                         s2_valid;
    logic [LANES*DATA_WIDTH-1:0]  s2_data;
    logic                         s2_last;
    logic                         s2_free;

    logic [LANES*DATA_WIDTH-1:0]  act_data;

    // Handshake, stall propagation and per-beat framing decisions
    always_comb begin
        s2_free   = !s2_valid || out_ready;
        s1_adv    = s1_valid && s2_free;
        in_ready  = !s1_valid || s1_adv;
        in_hs     = in_valid && in_ready;
        at_first  = (cnt == '0);
        at_last   = (cnt == LAST_BEAT);
        // Beat 0 takes the live mode; later beats reuse the value latched on beat 0
        beat_mode = at_first ? mode : mode_q;
        // A beat closes the vector at the counted end or on an early in_last
        beat_last = at_last || in_last;
    end

    // Beat counter, per-vector mode latch and length-error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            mode_q  <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= in_hs && (in_last != at_last);
            if (in_hs) begin
                if (at_first) begin
                    mode_q <= mode;
                end
                if (beat_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Stage 1 register: load on input handshake, empty when it drains forward
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
            s1_last  <= 1'b0;
        end else if (in_hs) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_mode  <= beat_mode;
            s1_last  <= beat_last;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Per-lane activation of the stage-1 beat
    always_comb begin
        logic signed [DATA_WIDTH-1:0] x;
        logic signed [DATA_WIDTH-1:0] y;
        act_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            x = $signed(s1_data[k*DATA_WIDTH +: DATA_WIDTH]);
            y = x;
            case (s1_mode)
                MODE_RELU: begin
                    if (x[DATA_WIDTH-1]) begin
                        y = '0;
                    end
                end
                MODE_LEAKY: begin
                    if (x[DATA_WIDTH-1]) begin
                        y = x >>> LEAK_SHIFT;
                    end
                end
                MODE_RELU6: begin
                    if (x[DATA_WIDTH-1]) begin
                        y = '0;
                    end else if (x > RELU6_MAX) begin
                        y = RELU6_MAX;
                    end
                end
                MODE_PASS: begin
                    y = x;
                end
                default: begin
                    y = x;
                end
            endcase
            act_data[k*DATA_WIDTH +: DATA_WIDTH] = y;
        end
    end

    // Stage 2 register: holds its beat steady until the consumer takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_data  <= act_data;
            s2_last  <= s1_last;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Completion pulse one cycle after the final beat leaves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= s2_valid && out_ready && s2_last;
        end
    end

    // Output and status wiring
    always_comb begin
        out_valid = s2_valid;
        out_data  = s2_data;
        out_last  = s2_last;
        busy      = (cnt != '0) || s1_valid || s2_valid;
    end

endmodule

// File: tb/tb_activation_unit.sv
// Directed testbench for activation_unit (16-bit Q8.8, 4 lanes, 32 beats/vector).
module tb_activation_unit;

    localparam int BEATS = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        out_last;
    logic        done;
    logic        busy;
    logic        len_err;

    always #5 clk = ~clk;

    activation_unit #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (8),
        .LANES      (4),
        .VEC_LEN    (128),
        .LEAK_SHIFT (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy),
        .len_err   (len_err)
    );

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int n_lerr = 0;
    logic bp_en = 1'b0;

    logic [63:0] rx_d[$];
    logic        rx_l[$];
    logic [63:0] ex_d[$];
    logic        ex_l[$];

    logic        prev_stall = 1'b0;
    logic [63:0] prev_d = '0;
    logic        prev_l = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] a0, input logic [15:0] a1,
                                       input logic [15:0] a2, input logic [15:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] ramp(input int base);
        return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
    endfunction

    // Output monitor: records accepted beats, counts pulses, checks stall stability
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", out_data, prev_d);
                chk("stall_last", 64'(out_last), 64'(prev_l));
            end
            if (out_valid && out_ready) begin
                rx_d.push_back(out_data);
                rx_l.push_back(out_last);
            end
            if (done)    n_done++;
            if (len_err) n_lerr++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    // Consumer: always ready, or random readiness during the backpressure test
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_log();
        rx_d.delete(); rx_l.delete();
        ex_d.delete(); ex_l.delete();
        n_done = 0;
        n_lerr = 0;
    endtask

    task automatic expect_beat(input logic [63:0] d, input logic l);
        ex_d.push_back(d);
        ex_l.push_back(l);
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input logic [63:0] d, input logic last, input logic [1:0] m);
        logic hs;
        hs       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("send_accepted", 64'(hs), 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
        end
        chk("drain_idle", 64'(busy), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic compare(input string tag);
        chk($sformatf("%s_count", tag), 64'(rx_d.size()), 64'(ex_d.size()));
        for (int i = 0; i < ex_d.size() && i < rx_d.size(); i++) begin
            chk($sformatf("%s_data[%0d]", tag, i), rx_d[i], ex_d[i]);
            chk($sformatf("%s_last[%0d]", tag, i), 64'(rx_l[i]), 64'(ex_l[i]));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // ReLU vector with a two-cycle latency check on beat 0
        clear_log();
        send(pk(16'h0000, 16'hF000, 16'h1000, 16'hFE00), 1'b0, 2'b00);
        expect_beat(pk(16'h0000, 16'h0000, 16'h1000, 16'h0000), 1'b0);
        chk("relu_lat1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("relu_lat2_valid", 64'(out_valid), 64'd1);
        chk("relu_lat2_data", out_data, pk(16'h0000, 16'h0000, 16'h1000, 16'h0000));
        for (int i = 1; i < BEATS; i++) begin
            send(ramp(i * 4), i == BEATS - 1, 2'b00);
            expect_beat(ramp(i * 4), i == BEATS - 1);
        end
        drain();
        compare("relu");
        chk("relu_done", 64'(n_done), 64'd1);
        chk("relu_len_err", 64'(n_lerr), 64'd0);

        // Leaky vector; later beats present ReLU mode, which must be ignored
        clear_log();
        send(pk(16'hFE00, 16'h0200, 16'hFFFF, 16'h8000), 1'b0, 2'b01);
        expect_beat(pk(16'hFFC0, 16'h0200, 16'hFFFF, 16'hF000), 1'b0);
        for (int i = 1; i < BEATS; i++) begin
            send(pk(16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00), i == BEATS - 1, 2'b00);
            expect_beat(pk(16'hFFC0, 16'hFFC0, 16'hFFC0, 16'hFFC0), i == BEATS - 1);
        end
        drain();
        compare("leaky");
        chk("leaky_done", 64'(n_done), 64'd1);
        chk("leaky_len_err", 64'(n_lerr), 64'd0);

        // ReLU6 vector; in_last withheld on the final beat
        clear_log();
        send(pk(16'h0700, 16'h0600, 16'h05FF, 16'hFF00), 1'b0, 2'b10);
        expect_beat(pk(16'h0600, 16'h0600, 16'h05FF, 16'h0000), 1'b0);
        for (int i = 1; i < BEATS; i++) begin
            send(pk(16'h0800, 16'h7FFF, 16'h0001, 16'h8000), 1'b0, 2'b10);
            expect_beat(pk(16'h0600, 16'h0600, 16'h0001, 16'h0000), i == BEATS - 1);
        end
        drain();
        compare("relu6");
        chk("relu6_done", 64'(n_done), 64'd1);
        chk("relu6_missing_last_err", 64'(n_lerr), 64'd1);

        // Pass-through ramp under random backpressure
        clear_log();
        bp_en = 1'b1;
        for (int i = 0; i < BEATS; i++) begin
            send(ramp(16'h0100 + i * 4), i == BEATS - 1, 2'b11);
            expect_beat(ramp(16'h0100 + i * 4), i == BEATS - 1);
        end
        drain();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare("bp");
        chk("bp_done", 64'(n_done), 64'd1);
        chk("bp_len_err", 64'(n_lerr), 64'd0);

        // Early in_last on beat 5, then a clean full vector
        clear_log();
        for (int i = 0; i < 6; i++) begin
            send(ramp(i * 4), i == 5, 2'b00);
            expect_beat(ramp(i * 4), i == 5);
        end
        drain();
        chk("early_len_err", 64'(n_lerr), 64'd1);
        chk("early_done", 64'(n_done), 64'd1);
        for (int i = 0; i < BEATS; i++) begin
            send(ramp(16'h0200 + i * 4), i == BEATS - 1, 2'b00);
            expect_beat(ramp(16'h0200 + i * 4), i == BEATS - 1);
        end
        drain();
        compare("early");
        chk("early_total_done", 64'(n_done), 64'd2);
        chk("early_total_len_err", 64'(n_lerr), 64'd1);

        // Mode change at beat 10, reset right after beat 19 is accepted
        clear_log();
        for (int i = 0; i < 20; i++) begin
            send(pk(16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00), 1'b0, (i < 10) ? 2'b01 : 2'b10);
        end
        for (int i = 0; i < 18; i++) begin
            expect_beat(pk(16'hFFC0, 16'hFFC0, 16'hFFC0, 16'hFFC0), 1'b0);
        end
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_out_last", 64'(out_last), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_len_err", 64'(len_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        compare("midrst");
        chk("midrst_no_done", 64'(n_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
